// File: rtl/alien_march_ctrl_if.sv
// Tick/control inputs and formation state outputs exchanged between the
// timing/sprite side (master) and the march controller (slave).
interface alien_march_ctrl_if;
  logic       tick;
  logic       enable;
  logic [7:0] step_period;
  logic [9:0] pos_x;
  logic [8:0] pos_y;
  logic       dir;
  logic       anim_frame;
  logic       step_pulse;
  logic       landed;

  modport master (
    output tick, enable, step_period,
    input  pos_x, pos_y, dir, anim_frame, step_pulse, landed
  );

  modport slave (
    input  tick, enable, step_period,
    output pos_x, pos_y, dir, anim_frame, step_pulse, landed
  );
endinterface

// File: rtl/alien_march_ctrl.sv
// Alien formation march controller: divides prescaler ticks by a runtime
// period, steps the formation sideways, drops and reverses at the edges.
module alien_march_ctrl #(
  parameter int X_START = 64,
  parameter int Y_START = 48,
  parameter int X_MIN   = 16,
  parameter int X_MAX   = 400,
  parameter int Y_LIMIT = 400,
  parameter int STEP_PX = 4,
  parameter int DROP_PX = 16
) (
  input  logic               CLK,
  input  logic               Rst,
  alien_march_ctrl_if.slave  bus
);

  localparam logic [9:0]  X_START_V = 10'(X_START);
  localparam logic [8:0]  Y_START_V = 9'(Y_START);
  localparam logic [10:0] X_MIN_W   = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
  localparam logic [10:0] Y_LIMIT_W = 11'(Y_LIMIT);
  localparam logic [10:0] STEP_W    = 11'(STEP_PX);
  localparam logic [10:0] DROP_W    = 11'(DROP_PX);

  logic [9:0] pos_x_q, pos_x_d;
  logic [8:0] pos_y_q, pos_y_d;
  logic       dir_q, dir_d;
  logic       anim_q, anim_d;
  logic       pulse_q, pulse_d;
  logic       landed_q, landed_d;
  logic [7:0] tcnt_q, tcnt_d;

  logic        armed;
  logic        fire;
  logic [7:0]  period_m1;
  logic [10:0] x_ext;
  logic [10:0] x_fwd;
  logic [10:0] x_back;
  logic [10:0] y_drop;
  logic        at_right_edge;
  logic        at_left_edge;

  // 11-bit zero-extended intermediates keep edge compares free of wrap-around.
  assign x_ext         = {1'b0, pos_x_q};
  assign x_fwd         = x_ext + STEP_W;
  assign x_back        = x_ext - STEP_W;
  assign y_drop        = {2'b00, pos_y_q} + DROP_W;
  assign at_right_edge = x_fwd > X_MAX_W;
  assign at_left_edge  = x_ext < (X_MIN_W + STEP_W);

  assign armed     = bus.tick & bus.enable & ~landed_q;
  assign period_m1 = (bus.step_period == 8'd0) ? 8'd0 : bus.step_period - 8'd1;
  // >= rather than == so a period lowered mid-count fires on the next tick.
  assign fire      = armed && (tcnt_q >= period_m1);

  always_comb begin
    tcnt_d   = tcnt_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    dir_d    = dir_q;
    anim_d   = anim_q;
    pulse_d  = 1'b0;
    landed_d = landed_q;

    if (fire) begin
      tcnt_d  = 8'd0;
      anim_d  = ~anim_q;
      pulse_d = 1'b1;
      if ((!dir_q && at_right_edge) || (dir_q && at_left_edge)) begin
        pos_y_d  = y_drop[8:0];
        dir_d    = ~dir_q;
        landed_d = (y_drop >= Y_LIMIT_W);
      end else if (!dir_q) begin
        pos_x_d = x_fwd[9:0];
      end else begin
        pos_x_d = x_back[9:0];
      end
    end else if (armed) begin
      tcnt_d = tcnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      pos_x_q  <= X_START_V;
      pos_y_q  <= Y_START_V;
      dir_q    <= 1'b0;
      anim_q   <= 1'b0;
      pulse_q  <= 1'b0;
      landed_q <= 1'b0;
      tcnt_q   <= 8'd0;
    end else begin
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      dir_q    <= dir_d;
      anim_q   <= anim_d;
      pulse_q  <= pulse_d;
      landed_q <= landed_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign bus.pos_x      = pos_x_q;
  assign bus.pos_y      = pos_y_q;
  assign bus.dir        = dir_q;
  assign bus.anim_frame = anim_q;
  assign bus.step_pulse = pulse_q;
  assign bus.landed     = landed_q;

endmodule
